seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_hex_decoder.sv | 32 +++
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a} with a in bit 0.
package seg7_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low anode vector that enables only digit idx.
    function automatic logic [3:0] digit_anode(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Purely combinational nibble to active-low seven-segment decoder
// covering the full hex range 0-9, A, b, C, d, E, F.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit seven-segment driver with inter-digit blanking
// and frame-synchronous display updates. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter logic [19:0] REFRESH_LIMIT = 20'h0FFFF,
    parameter logic [7:0]  BLANK_LIMIT   = 8'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_n_q, dp_n_d;

    logic [19:0] active_limit;
    logic        interval_done;
    logic        frame_boundary;
    logic [3:0]  cur_nibble;
    logic [6:0]  dec_seg;
    logic [6:0]  drive_seg;

    assign active_limit   = (state_q == DRIVE) ? REFRESH_LIMIT : {12'd0, BLANK_LIMIT};
    assign interval_done  = (cnt_q == active_limit);
    assign frame_boundary = (state_q == BLANK) && interval_done && (digit_q == 2'd3);

    assign cur_nibble = disp_q[{digit_q, 2'b00} +: 4];

    seg7_hex_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead_blank;

    // A digit is suppressed only when it and every higher digit are zero.
    always_comb begin
        lead_blank = 1'b0;
        case (digit_q)
            2'd3:    lead_blank = (disp_q[15:12] == 4'h0);
            2'd2:    lead_blank = (disp_q[15:8]  == 8'h00);
            2'd1:    lead_blank = (disp_q[15:4]  == 12'h000);
            default: lead_blank = 1'b0;
        endcase
    end

    assign drive_seg = lead_blank ? SEG_OFF : dec_seg;
`else
    assign drive_seg = dec_seg;
`endif

    // Scan sequencing: DRIVE and BLANK alternate; the digit advances on BLANK exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 20'd1;
        digit_d = digit_q;
        if (interval_done) begin
            cnt_d = 20'd0;
            if (state_q == DRIVE) begin
                state_d = BLANK;
            end else begin
                state_d = DRIVE;
                digit_d = digit_q + 2'd1;
            end
        end
    end

    // load is a one-cycle pulse with no back-pressure: it always lands in the
    // shadow, and pending stays high until the next frame boundary applies it.
    // A load on the boundary edge itself bypasses the shadow straight to display.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pending_d   = pending_q;
        if (load) begin
            shadow_d    = value_in;
            shadow_dp_d = dp_in;
        end
        if (frame_boundary) begin
            if (load) begin
                disp_d    = value_in;
                disp_dp_d = dp_in;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        if (state_q == DRIVE) begin
            an_d   = digit_anode(digit_q);
            seg_d  = drive_seg;
            dp_n_d = ~disp_dp_q[digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DRIVE;
            cnt_q       <= 20'd0;
            digit_q     <= 2'd0;
            shadow_q    <= 16'h0000;
            shadow_dp_q <= 4'h0;
            disp_q      <= 16'h0000;
            disp_dp_q   <= 4'h0;
            pending_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp_n    = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_LIMIT=3, BLANK_LIMIT=1:
// each digit slot is 4 drive + 2 blank cycles, so a full frame is 24 cycles.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_checks;
    int n_errors;
    int k;

    seg7_scan_driver #(
        .REFRESH_LIMIT (20'd3),
        .BLANK_LIMIT   (8'd1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .pending  (pending),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Advance one edge; inputs written after this return are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    // Outputs after edge k reflect the scan position k-1 cycles after reset release.
    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dpn, input logic exp_pend);
        for (int i = 0; i < 24; i++) begin
            int p;
            int d;
            logic [3:0] exp_an;
            step();
            p = k - 1;
            d = (p / 6) % 4;
            if ((p % 6) < 4) begin
                exp_an = 4'hF;
                exp_an[d] = 1'b0;
                check("an_drive", an, exp_an);
                check("seg_drive", seg, segs[d*7 +: 7]);
                check("dp_n_drive", dp_n, dpn[d]);
            end else begin
                check("an_blank", an, 4'hF);
                check("seg_blank", seg, 7'h7F);
                check("dp_n_blank", dp_n, 1'b1);
            end
            check("pending_frame", pending, exp_pend);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_pending", pending, 1'b0);
        reset = 1'b0;
        k = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        k        = 0;
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        dp_in    = 4'h0;

        do_reset();

        // Free-run from reset: all digits show "0", no decimal points.
        run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0);
        run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0);

        // Mid-frame load is held pending until the wrap to digit 0 (edge 72).
        step_to(55);
        load = 1'b1; value_in = 16'h12AF; dp_in = 4'b0100;
        step();
        load = 1'b0;
        while (k < 71) begin
            check("pending_held", pending, 1'b1);
            step();
        end
        check("pending_before_wrap", pending, 1'b1);
        step();
        check("pending_cleared", pending, 1'b0);
        run_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 1'b0);

        // Two loads in one frame: the later one wins at boundary edge 120.
        step_to(99);
        load = 1'b1; value_in = 16'h1111; dp_in = 4'b0000;
        step();
        load = 1'b0;
        step_to(109);
        load = 1'b1; value_in = 16'h2222; dp_in = 4'b0000;
        step();
        load = 1'b0;
        check("pending_two_loads", pending, 1'b1);
        step_to(120);
        check("pending_after_two", pending, 1'b0);
        run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 1'b0);

        // Load landing exactly on boundary edge 168 goes straight to display.
        step_to(167);
        load = 1'b1; value_in = 16'hC0DE; dp_in = 4'b1000;
        step();
        load = 1'b0;
        check("pending_on_boundary", pending, 1'b0);
        run_frame({7'h46, 7'h40, 7'h21, 7'h06}, 4'b0111, 1'b0);

        // Reset during digit 2 DRIVE with a load pending.
        step_to(198);
        load = 1'b1; value_in = 16'h5555; dp_in = 4'b1111;
        step();
        load = 1'b0;
        step_to(205);
        check("pre_reset_pending", pending, 1'b1);
        check("pre_reset_an", an, 4'b1011);
        check("pre_reset_seg", seg, 7'h40);
        do_reset();
        run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0);
        run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        step_to(53);
        load = 1'b1; value_in = 16'h0050; dp_in = 4'b0000;
        step();
        load = 1'b0;
        step_to(72);
        run_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
